// File: rtl/rollout_scheduler_if.sv
// Handshake bundle between the game FSM, the rollout scheduler and the shared
// rollout engine. The scheduler takes the master view; the environment takes the slave view.
interface rollout_scheduler_if #(
  parameter int SCORE_W = 36
);
  logic               start;
  logic [3:0]         cand_valid;
  logic               eng_start;
  logic [1:0]         eng_sel;
  logic               eng_done;
  logic [SCORE_W-1:0] eng_score;
  logic               busy;
  logic               done;
  logic [2:0]         best_dir;
  logic               timeout_err;

  modport master (
    input  start, cand_valid, eng_done, eng_score,
    output eng_start, eng_sel, busy, done, best_dir, timeout_err
  );

  modport slave (
    output start, cand_valid, eng_done, eng_score,
    input  eng_start, eng_sel, busy, done, best_dir, timeout_err
  );
endinterface

// File: rtl/rollout_scheduler.sv
// Shares one Monte-Carlo rollout engine across the four 2048 candidate moves and
// picks the best-scoring one. Optional macro SCHED_SINGLE_CAND_SKIP_EN skips rollouts for a lone candidate.
module rollout_scheduler #(
  parameter int NUM_ROLL = 8,
  parameter int SCORE_W  = 36,
  parameter int ACC_W    = 40,
  parameter int TIMEOUT  = 4096
) (
  input  logic clk,
  input  logic rst,
  rollout_scheduler_if.master bus
);
  localparam int ROLL_W = (NUM_ROLL > 1) ? $clog2(NUM_ROLL) : 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int SUM_W  = ((ACC_W > SCORE_W) ? ACC_W : SCORE_W) + 1;
  localparam logic [SUM_W-1:0] ACC_MAX = SUM_W'({ACC_W{1'b1}});

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DECIDE} state_e;
  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  // Lowest set bit of m at or above position lo.
  function automatic pick_t next_set(input logic [3:0] m, input int lo);
    pick_t p;
    p = '0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i] && i >= lo) begin
        p.found = 1'b1;
        p.idx   = 2'(i);
      end
    end
    return p;
  endfunction

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [SCORE_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    return (s > ACC_MAX) ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  state_e             state_q, state_d;
  logic [3:0]         mask_q, mask_d;
  logic [1:0]         cur_q, cur_d;
  logic [ROLL_W-1:0]  roll_q, roll_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [ACC_W-1:0]   acc_q [4];
  logic [ACC_W-1:0]   acc_d [4];
  logic [2:0]         best_dir_q, best_dir_d;
  logic               done_q, done_d;
  logic               timeout_err_q, timeout_err_d;

  pick_t              first_s, next_s;
  logic               single_cand;
  logic               finish;
  logic [2:0]         best_dir_c;
  logic [ACC_W-1:0]   best_acc;

  assign first_s = next_set(bus.cand_valid, 0);
  assign next_s  = next_set(mask_q, int'(cur_q) + 1);

`ifdef SCHED_SINGLE_CAND_SKIP_EN
  assign single_cand = (bus.cand_valid != 4'd0) &&
                       ((bus.cand_valid & (bus.cand_valid - 4'd1)) == 4'd0);
`else
  assign single_cand = 1'b0;
`endif

  // Highest masked total; ascending scan with strict '>' gives UP > DOWN > LEFT > RIGHT on ties.
  always_comb begin
    best_dir_c = 3'd0;
    best_acc   = '0;
    for (int i = 0; i < 4; i++) begin
      if (mask_q[i] && (best_dir_c == 3'd0 || acc_q[i] > best_acc)) begin
        best_dir_c = 3'(i + 1);
        best_acc   = acc_q[i];
      end
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d       = state_q;
    mask_d        = mask_q;
    cur_d         = cur_q;
    roll_d        = roll_q;
    wait_d        = wait_q;
    acc_d         = acc_q;
    best_dir_d    = best_dir_q;
    done_d        = 1'b0;
    timeout_err_d = timeout_err_q;
    finish        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mask_d        = bus.cand_valid;
          acc_d         = '{default: '0};
          timeout_err_d = 1'b0;
          roll_d        = '0;
          if (!first_s.found || single_cand) begin
            state_d = S_DECIDE;
          end else begin
            cur_d   = first_s.idx;
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wait_d = wait_q + 1'b1;
        if (bus.eng_done) begin
          acc_d[cur_q] = sat_add(acc_q[cur_q], bus.eng_score);
          finish       = 1'b1;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          finish        = 1'b1;
        end
        if (finish) begin
          if (roll_q != ROLL_W'(NUM_ROLL - 1)) begin
            roll_d  = roll_q + 1'b1;
            state_d = S_LAUNCH;
          end else if (next_s.found) begin
            cur_d   = next_s.idx;
            roll_d  = '0;
            state_d = S_LAUNCH;
          end else begin
            state_d = S_DECIDE;
          end
        end
      end
      S_DECIDE: begin
        best_dir_d = best_dir_c;
        done_d     = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      mask_q        <= '0;
      cur_q         <= '0;
      roll_q        <= '0;
      wait_q        <= '0;
      // NOTE: the four accumulators are plain flops, not a RAM, so they reset with everything else.
      acc_q         <= '{default: '0};
      best_dir_q    <= '0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates keep every register sampling pre-edge values.
      state_q       <= state_d;
      mask_q        <= mask_d;
      cur_q         <= cur_d;
      roll_q        <= roll_d;
      wait_q        <= wait_d;
      acc_q         <= acc_d;
      best_dir_q    <= best_dir_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.eng_start   = (state_q == S_LAUNCH);
  assign bus.eng_sel     = cur_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;
  assign bus.best_dir    = best_dir_q;
  assign bus.timeout_err = timeout_err_q;
endmodule

// File: doc/rollout_scheduler.md
Name: rollout_scheduler

Overview:
Time-multiplexes one Monte-Carlo rollout engine across the four candidate moves (UP/DOWN/LEFT/RIGHT) of the 2048 AI.
- On `start`, it runs NUM_ROLL rollouts per legal candidate and accumulates the engine scores per direction.
- It then selects the direction with the highest total and pulses `done` with `best_dir`.
- It sits between the top-level game FSM (which issues `start` in INPUT state) and a single shared rollout engine. This replaces four parallel engines.

Parameters:
NUM_ROLL, 8, rollouts per candidate direction (>=1)
SCORE_W, 36, width of one engine score
ACC_W, 40, per-direction accumulator width (saturating)
TIMEOUT, 4096, max cycles to wait for eng_done before abandoning a rollout

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
start  in  1  request a search; sampled only in IDLE
cand_valid  in  4  legal-move mask; bit0=UP, bit1=DOWN, bit2=LEFT, bit3=RIGHT; sampled with start
eng_start  out  1  one-cycle pulse launching a rollout
eng_sel  out  2  candidate index the engine loads; stable from eng_start until eng_done
eng_done  in  1  engine finished; eng_score valid this cycle
eng_score  in  SCORE_W  rollout score
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse, best_dir valid
best_dir  out  3  1=UP, 2=DOWN, 3=LEFT, 4=RIGHT, 0=no legal move; held until next done
timeout_err  out  1  sticky; set on any rollout timeout, cleared on next accepted start

Behaviour:
- Reset (rst=0, async): state IDLE; all accumulators, counters and outputs = 0.
- FSM states: IDLE, LAUNCH, WAIT, DECIDE.
- IDLE:
  - start=1: latch cand_valid into mask, clear accumulators and timeout_err.
  - mask==0: go to DECIDE directly.
  - otherwise: cur = lowest set bit of mask, roll=0, go to LAUNCH.
- LAUNCH: eng_start=1, eng_sel=cur for one cycle; then WAIT with wait counter reset.
- WAIT:
  - eng_done=1: acc[cur] += eng_score, saturating at 2^ACC_W-1.
  - Timeout: wait counter reaches TIMEOUT-1 with no eng_done. Add 0, set timeout_err, and treat the rollout as finished.
  - After a finish:
    - roll<NUM_ROLL-1: roll++ and return to LAUNCH.
    - Otherwise: cur = next higher set bit of mask, roll=0, go to LAUNCH.
    - If no higher set bit remains: go to DECIDE.
- DECIDE (one cycle):
  - best_dir = index+1 of the maximum acc among masked directions.
  - Tie priority: UP > DOWN > LEFT > RIGHT.
  - mask==0 gives best_dir=0.
  - Registers best_dir, pulses done the following cycle, returns to IDLE.
- Latency: for engine latency L (eng_start to eng_done) and k legal moves, done occurs k·NUM_ROLL·(L+1)+2 cycles after the start cycle. With mask==0, done occurs 2 cycles after start.
- Ignored inputs:
  - start while busy.
  - eng_done outside WAIT.
  - changes to cand_valid after sampling.
- Unmasked directions never launch and never win.
- Reset asserted mid-search aborts immediately. No done is emitted, eng_start drops to 0, best_dir returns to 0.
- busy=0 in IDLE; done and busy are never high simultaneously.

Optional Feature:
Macro SCHED_SINGLE_CAND_SKIP_EN.
- Defined: if exactly one cand_valid bit is set at start, no rollouts run. The FSM goes straight to DECIDE and best_dir is that direction; done follows 2 cycles after start, and eng_start never pulses.
- Undefined: single-candidate searches run the full NUM_ROLL rollouts like any other mask.

Test Plan:
- Engine model L=3, scores UP=10, DOWN=20, LEFT=30, RIGHT=5; NUM_ROLL=2; cand_valid=4'b1111 -> 8 eng_start pulses with eng_sel sequence 0,0,1,1,2,2,3,3; done at cycle 34 after start; best_dir=3.
- cand_valid=4'b0000 -> no eng_start; done 2 cycles after start; best_dir=0.
- cand_valid=4'b0101, equal scores 7 -> only eng_sel 0 and 2 launched; best_dir=1 (tie to UP).
- Engine withholds eng_done for DOWN's first rollout, TIMEOUT=16 -> timeout_err=1, DOWN gets +0, search completes; next start clears timeout_err.
- eng_score=2^36-1 every rollout, ACC_W=36 -> acc saturates, no wrap; start pulsed while busy is ignored; rst pulled low mid-WAIT -> busy/eng_start/best_dir=0 immediately, no done.
- With SCHED_SINGLE_CAND_SKIP_EN, cand_valid=4'b1000 -> no eng_start, best_dir=4, done 2 cycles after start; without the macro -> NUM_ROLL rollouts on eng_sel=3, then best_dir=4.
